// File: rtl/enc_frame_ctrl_if.sv
// Compute-pipeline handshake and per-channel code output bus of the ADPCM frame controller.
// The controller drives the master side; the compute pipeline and the output sink sit on the slave side.
interface enc_frame_ctrl_if #(
   parameter int CH_W = 5,
   parameter int CW   = 5,
   parameter int OW   = 8
);
   logic            fa_start;
   logic            fa_done;
   logic            dly_strb;
   logic [CW-1:0]   code_in;
   logic [CH_W-1:0] ch_idx;
   logic [OW-1:0]   data_out;
   logic            data_valid;

   modport master (
      output fa_start, dly_strb, ch_idx, data_out, data_valid,
      input  fa_done, code_in
   );

   modport slave (
      input  fa_start, dly_strb, ch_idx, data_out, data_valid,
      output fa_done, code_in
   );
endinterface

// File: rtl/enc_frame_ctrl.sv
// Multi-channel ADPCM frame controller: recovers channel ticks and frame sync, sequences the shared
// compute pipeline once per channel and double-buffers the per-channel codes for output.
module enc_frame_ctrl #(
   parameter int NUM_CH = 32,
   parameter int CH_W   = 5,
   parameter int CW     = 5,
   parameter int OW     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ch_clk_in,
   input  logic             fs_in,
   input  logic [1:0]       rate,
   enc_frame_ctrl_if.master bus,
   output logic             busy,
   output logic             err_overrun
);
   typedef enum logic [2:0] {IDLE, START, WAIT, STROBE, WRITE} state_t;

   state_t          state_reg, state_next;
   logic            ch_s1_reg, ch_s2_reg, ch_s3_reg;
   logic            fs_s1_reg, fs_s2_reg;
   logic            tick, fs_s;
   logic [CH_W-1:0] ch_cnt_reg, ch_cnt_next;
   logic [CH_W-1:0] ch_idx_reg;
   logic            wbank_reg, wbank_next;
   logic [OW-1:0]   data_out_reg;
   logic            data_valid_reg;
   logic            err_reg;
   logic            fa_start_c, dly_strb_c, busy_c;
   logic [CW-1:0]   wr_code, rd_code;

   function automatic logic [CW-1:0] rate_mask(input logic [1:0] r);
      int            keep;
      logic [CW-1:0] m;
      case (r)
         2'b00:   keep = 4;
         2'b01:   keep = 3;
         2'b10:   keep = 2;
         default: keep = 5;
      endcase
      for (int i = 0; i < CW; i++) m[i] = (i < keep);
      return m;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch_s1_reg <= 1'b0;
         ch_s2_reg <= 1'b0;
         ch_s3_reg <= 1'b0;
         fs_s1_reg <= 1'b0;
         fs_s2_reg <= 1'b0;
      end else begin
         ch_s1_reg <= ch_clk_in;
         ch_s2_reg <= ch_s1_reg;
         ch_s3_reg <= ch_s2_reg;
         fs_s1_reg <= fs_in;
         fs_s2_reg <= fs_s1_reg;
      end
   end

   assign tick = ch_s2_reg & ~ch_s3_reg;
   assign fs_s = fs_s2_reg;

   // Frame sync always toggles the bank, even if the counter is already at channel 0.
   always_comb begin
      ch_cnt_next = ch_cnt_reg;
      wbank_next  = wbank_reg;
      if (tick) begin
         if (fs_s) begin
            ch_cnt_next = '0;
            wbank_next  = ~wbank_reg;
         end else if (ch_cnt_reg == CH_W'(NUM_CH - 1)) begin
            ch_cnt_next = '0;
         end else begin
            ch_cnt_next = ch_cnt_reg + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      fa_start_c = 1'b0;
      dly_strb_c = 1'b0;
      busy_c     = 1'b1;
      case (state_reg)
         IDLE: begin
            busy_c = 1'b0;
            if (tick) state_next = START;
         end
         START: begin
            fa_start_c = 1'b1;
            state_next = WAIT;
         end
         WAIT:    if (bus.fa_done) state_next = STROBE;
         STROBE: begin
            dly_strb_c = 1'b1;
            state_next = WRITE;
         end
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         ch_cnt_reg     <= '0;
         wbank_reg      <= 1'b0;
         ch_idx_reg     <= '0;
         data_out_reg   <= '0;
         data_valid_reg <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         ch_cnt_reg     <= ch_cnt_next;
         wbank_reg      <= wbank_next;
         data_valid_reg <= tick;
         if (tick && state_reg == IDLE) ch_idx_reg <= ch_cnt_next;
         if (tick && state_reg != IDLE) err_reg <= 1'b1;
         if (tick) data_out_reg <= OW'(rd_code & rate_mask(rate));
      end
   end

   assign wr_code = bus.code_in & rate_mask(rate);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         logic [CW-1:0] mem_reg [NUM_CH];
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < NUM_CH; i++) mem_reg[i] <= '0;
            end else if (state_reg == WRITE && wbank_reg == 1'(gi)) begin
               mem_reg[ch_idx_reg] <= wr_code;
            end
         end
      end
   endgenerate

   // The read side always looks at the bank that the new frame is not writing.
   assign rd_code = wbank_next ? g_bank[0].mem_reg[ch_cnt_next] : g_bank[1].mem_reg[ch_cnt_next];

   assign bus.fa_start   = fa_start_c;
   assign bus.dly_strb   = dly_strb_c;
   assign bus.ch_idx     = ch_idx_reg;
   assign bus.data_out   = data_out_reg;
   assign bus.data_valid = data_valid_reg;
   assign busy           = busy_c;
   assign err_overrun    = err_reg;
endmodule
